// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA modular-exponentiation core.
// Holds the FSM state encoding and the exponent length helper.
package rsa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MONT,
        S_CALC,
        S_DONE
    } state_t;

    // Widest key the length helper can scan; cores may not exceed it.
    localparam int MSB_MAX_W = 1024;

    // Returns 1 + index of the highest set bit, or 0 for an all-zero key.
    function automatic int unsigned msb_index(
        input logic [MSB_MAX_W-1:0] key
    );
        int unsigned r;
        r = 0;
        for (int i = 0; i < MSB_MAX_W; i++) begin
            if (key[i]) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rsa_mont_mul.sv
// Radix-2 Montgomery multiplier: o_r = a*b*2^-WIDTH mod n.
// Fixed WIDTH+1-cycle latency; the start edge already runs the first step.
module rsa_mont_mul #(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    output logic             o_fin,
    output logic [WIDTH-1:0] o_r
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] acc_first;
    logic [WIDTH+1:0] acc_step;
    logic [CNT_W-1:0] cnt;
    logic             run;

    // One radix-2 step: add a_i*b, make even with n, halve.
    // acc stays below b+n < 2n, so the sum fits in WIDTH+2 bits.
    function automatic logic [WIDTH+1:0] mstep(
        input logic [WIDTH+1:0] acc_in,
        input logic             bit_a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH+1:0] s;
        s = acc_in + (bit_a ? {2'b00, b} : '0);
        if (s[0]) s = s + {2'b00, n};
        return s >> 1;
    endfunction

    // Next accumulator for the loading edge and for later iterations.
    always_comb begin
        acc_first = mstep('0, i_a[0], i_b, i_n);
        acc_step  = mstep(acc, a_sh[0], b_r, n_r);
    end

    // Iterate over the bits of a, then one conditional subtract.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_sh  <= '0;
            b_r   <= '0;
            n_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            o_fin <= 1'b0;
            o_r   <= '0;
        end else begin
            o_fin <= 1'b0;
            if (i_start) begin
                a_sh <= i_a >> 1;
                b_r  <= i_b;
                n_r  <= i_n;
                acc  <= acc_first;
                cnt  <= CNT_W'(1);
                run  <= 1'b1;
            end else if (run) begin
                if (cnt == LAST) begin
                    if (acc >= {2'b00, n_r}) begin
                        o_r <= acc[WIDTH-1:0] - n_r;
                    end else begin
                        o_r <= acc[WIDTH-1:0];
                    end
                    o_fin <= 1'b1;
                    run   <= 1'b0;
                end else begin
                    acc  <= acc_step;
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rsa_modexp_core.sv
// Montgomery modular exponentiation: o_ans = i_msg^i_key mod i_n.
// Right-to-left binary method; leading zero key bits are skipped.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_msg,
    input  logic [WIDTH-1:0] i_key,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_ans,
    output logic             o_finished,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    state_t               state;
    logic [WIDTH-1:0]     n_r;
    logic [WIDTH-1:0]     key_sh;
    logic [WIDTH-1:0]     t;
    logic [WIDTH-1:0]     m;
    logic [WIDTH-1:0]     t_nxt;
    logic [WIDTH-1:0]     m_nxt;
    logic [WIDTH-1:0]     t_prep;
    logic [WIDTH:0]       t_dbl;
    logic [WIDTH-1:0]     mul_r;
    logic [WIDTH-1:0]     sqr_r;
    logic                 mul_fin;
    logic                 sqr_fin;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic [CNT_W-1:0]     r_len;
    logic [CNT_W-1:0]     r_len_in;
    logic [MSB_MAX_W-1:0] key_ext;
    logic                 prep_last;
    logic                 calc_last;
    logic                 go_mont;

    assign o_busy = (state != S_IDLE);

    // Number of exponent rounds, taken from the key being latched.
    always_comb begin
        key_ext              = '0;
        key_ext[WIDTH-1:0]   = i_key;
        r_len_in             = CNT_W'(msb_index(key_ext));
    end

    // Modular doubling for the 2^WIDTH pre-scale of the base.
    always_comb begin
        t_dbl = {t, 1'b0};
        if (t_dbl >= {1'b0, n_r}) begin
            t_prep = t_dbl[WIDTH-1:0] - n_r;
        end else begin
            t_prep = t_dbl[WIDTH-1:0];
        end
    end

    // Round bookkeeping and multiplier launch.
    // Launch coincides with entering MONT so results land on its last cycle.
    always_comb begin
        cnt_inc   = cnt + CNT_W'(1);
        prep_last = (cnt == CNT_W'(WIDTH - 1));
        calc_last = (cnt_inc == r_len);
        go_mont   = 1'b0;
        if (!i_abort) begin
            if (state == S_PREP && prep_last && r_len != '0) begin
                go_mont = 1'b1;
            end else if (state == S_CALC && !calc_last) begin
                go_mont = 1'b1;
            end
        end
    end

    // Next values of the accumulator m and the running square t.
    always_comb begin
        t_nxt = t;
        m_nxt = m;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    t_nxt = i_msg;
                    m_nxt = WIDTH'(1);
                end
            end
            S_PREP: t_nxt = t_prep;
            S_CALC: begin
                t_nxt = sqr_r;
                if (key_sh[0]) m_nxt = mul_r;
            end
            default: ;
        endcase
    end

    rsa_mont_mul #(.WIDTH(WIDTH)) u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (go_mont),
        .i_a     (m_nxt),
        .i_b     (t_nxt),
        .i_n     (n_r),
        .o_fin   (mul_fin),
        .o_r     (mul_r)
    );

    rsa_mont_mul #(.WIDTH(WIDTH)) u_sqr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (go_mont),
        .i_a     (t_nxt),
        .i_b     (t_nxt),
        .i_n     (n_r),
        .o_fin   (sqr_fin),
        .o_r     (sqr_r)
    );

    // Datapath registers for m and t.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            t <= '0;
            m <= '0;
        end else begin
            t <= t_nxt;
            m <= m_nxt;
        end
    end

    // Control FSM with latched operands and registered result outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            n_r        <= '0;
            key_sh     <= '0;
            r_len      <= '0;
            cnt        <= '0;
            o_ans      <= '0;
            o_finished <= 1'b0;
        end else begin
            o_finished <= 1'b0;
            if (state != S_IDLE && i_abort) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            state  <= S_PREP;
                            n_r    <= i_n;
                            key_sh <= i_key;
                            r_len  <= r_len_in;
                            cnt    <= '0;
                        end
                    end
                    S_PREP: begin
                        if (prep_last) begin
                            cnt   <= '0;
                            state <= (r_len == '0) ? S_DONE : S_MONT;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_MONT: begin
                        if (mul_fin && sqr_fin) state <= S_CALC;
                    end
                    S_CALC: begin
                        key_sh <= key_sh >> 1;
                        cnt    <= cnt_inc;
                        state  <= calc_last ? S_DONE : S_MONT;
                    end
                    S_DONE: begin
                        o_ans      <= m;
                        o_finished <= 1'b1;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
